// File: rtl/pipelined_cla_adder_pkg.sv
`default_nettype none
// ============================================================================
// cla_pkg : shared defaults and result record for the pipelined CLA adder
// Revision: 1.0
// ============================================================================
package cla_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_GROUP = 4;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] sum;
        logic                     c_out;
        logic                     ovf;
    } cla_result_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// ============================================================================
// pipelined_cla_adder_if : operand/result valid-ready bus of the CLA adder
// Revision: 1.0
// ============================================================================
interface pipelined_cla_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_group.sv
`default_nettype none
// ============================================================================
// cla_group : GROUP-bit carry-lookahead block producing sum, group G and P
// Revision: 1.0
// ============================================================================
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             c_in_i,
    output logic [GROUP-1:0] sum_o,
    output logic             g_o,
    output logic             p_o
);
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    // G/P kept apart from the sum block so they never appear to depend on c_in_i
    always_comb begin : group_gp
        logic v_g;
        v_g = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            v_g = w_g[i] | (w_p[i] & v_g);
        end
        g_o = v_g;
        p_o = &w_p;
    end

    always_comb begin : group_sum
        logic v_c;
        v_c   = c_in_i;
        sum_o = '0;
        for (int i = 0; i < GROUP; i++) begin
            sum_o[i] = w_p[i] ^ v_c;
            v_c      = w_g[i] | (w_p[i] & v_c);
        end
    end
endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// pipelined_cla_adder : two-stage add/subtract with valid-ready flow control
// Revision: 1.0
// ============================================================================
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam int NGH  = HALF / GROUP;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_in;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_adv;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [HALF-1:0]  lo_q;
    logic [HALF-1:0]  a_hi_q;
    logic [HALF-1:0]  b_hi_q;
    logic             c_mid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    assign w_b_eff = bus.b ^ {WIDTH{bus.sub}};
    assign w_c_in  = bus.sub | bus.c_in;

    // ---------------- stage 1: lower half ----------------
    logic [HALF-1:0] w_sum_lo;
    logic [NGH-1:0]  w_g_lo, w_p_lo, w_c_lo;
    logic            w_c_mid;

    for (genvar gi = 0; gi < NGH; gi++) begin : g_lo
        cla_group #(.GROUP(GROUP)) u_grp (
            .a_i    (bus.a[gi*GROUP +: GROUP]),
            .b_i    (w_b_eff[gi*GROUP +: GROUP]),
            .c_in_i (w_c_lo[gi]),
            .sum_o  (w_sum_lo[gi*GROUP +: GROUP]),
            .g_o    (w_g_lo[gi]),
            .p_o    (w_p_lo[gi])
        );
    end

    always_comb begin : lookahead_lo
        logic v_c;
        w_c_lo = '0;
        v_c    = w_c_in;
        for (int i = 0; i < NGH; i++) begin
            w_c_lo[i] = v_c;
            v_c       = w_g_lo[i] | (w_p_lo[i] & v_c);
        end
        w_c_mid = v_c;
    end

    // ---------------- stage 2: upper half ----------------
    logic [HALF-1:0] w_sum_hi;
    logic [NGH-1:0]  w_g_hi, w_p_hi, w_c_hi;
    logic            w_c_out;
    logic            w_c_msb;

    for (genvar gi = 0; gi < NGH; gi++) begin : g_hi
        cla_group #(.GROUP(GROUP)) u_grp (
            .a_i    (a_hi_q[gi*GROUP +: GROUP]),
            .b_i    (b_hi_q[gi*GROUP +: GROUP]),
            .c_in_i (w_c_hi[gi]),
            .sum_o  (w_sum_hi[gi*GROUP +: GROUP]),
            .g_o    (w_g_hi[gi]),
            .p_o    (w_p_hi[gi])
        );
    end

    always_comb begin : lookahead_hi
        logic v_c;
        w_c_hi = '0;
        v_c    = c_mid_q;
        for (int i = 0; i < NGH; i++) begin
            w_c_hi[i] = v_c;
            v_c       = w_g_hi[i] | (w_p_hi[i] & v_c);
        end
        w_c_out = v_c;
    end

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c
    assign w_c_msb = w_sum_hi[HALF-1] ^ a_hi_q[HALF-1] ^ b_hi_q[HALF-1];

    // ---------------- flow control ----------------
    assign w_in_ready = ~v1_q | ~v2_q | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_adv      = v1_q & (~v2_q | bus.out_ready);
    assign v1_d       = w_accept | (v1_q & ~w_adv);
    assign v2_d       = w_adv | (v2_q & ~bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (w_adv) begin
                sum_q   <= {w_sum_hi, lo_q};
                c_out_q <= w_c_out;
                ovf_q   <= w_c_msb ^ w_c_out;
            end
        end
    end

    // Stage-1 payload is meaningless while v1_q is low, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            lo_q    <= w_sum_lo;
            c_mid_q <= w_c_mid;
            a_hi_q  <= bus.a[WIDTH-1:HALF];
            b_hi_q  <= w_b_eff[WIDTH-1:HALF];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = v2_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// tb_pipelined_cla_adder : directed and randomised scoreboard bench
// Revision: 1.0
// ============================================================================
module tb_pipelined_cla_adder;
    import cla_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cyc;
    int   acc_cyc;
    cla_result_t sb[$];
    int          pop_cyc[$];

    pipelined_cla_adder_if #(.WIDTH(32)) bus ();

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic cla_result_t mk(input logic [31:0] s, input logic c, input logic o);
        cla_result_t r;
        r.sum   = s;
        r.c_out = c;
        r.ovf   = o;
        return r;
    endfunction

    function automatic cla_result_t model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic s);
        logic [31:0] be;
        logic [32:0] full;
        logic [31:0] low;
        logic        cin;
        be   = s ? ~b : b;
        cin  = s ? 1'b1 : ci;
        full = {1'b0, a} + {1'b0, be} + {32'd0, cin};
        low  = {1'b0, a[30:0]} + {1'b0, be[30:0]} + {31'd0, cin};
        return mk(full[31:0], full[32], low[31] ^ full[32]);
    endfunction

    // Compares every result the DUT hands over against the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", bus.sum, 32'hDEAD_BEEF);
            end else begin
                cla_result_t e;
                cla_result_t g;
                e = sb.pop_front();
                g = mk(bus.sum, bus.c_out, bus.ovf);
                checks++;
                assert (g === e) else begin
                    errors++;
                    $error("FAIL result observed=%h/%b/%b expected=%h/%b/%b",
                           g.sum, g.c_out, g.ovf, e.sum, e.c_out, e.ovf);
                end
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic s, input cla_result_t exp, input bit rnd);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = ci;
        bus.sub      = s;
        for (int i = 0; i < 64; i++) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(exp);
                acc_cyc = cyc;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 32'(bus.in_ready), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] da[4];
        logic [31:0] db[4];
        logic [31:0] held;
        bit          have;
        int          idx;
        int          nacc;
        int          first;

        errors = 0; checks = 0; cyc = 0; acc_cyc = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        bus.sub = 1'b0; bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready",  32'(bus.in_ready), 1);
        chk("rst_sum",       bus.sum, 0);
        chk("rst_c_out",     32'(bus.c_out), 0);
        chk("rst_ovf",       32'(bus.ovf), 0);
        rst_n = 1'b1;

        // Directed corner values with 2-cycle latency check
        pop_cyc.delete();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0), 0);
        bus.in_valid = 1'b0;
        first = acc_cyc;
        drain();
        chk("lat_n", pop_cyc.size(), 1);
        if (pop_cyc.size() >= 1) chk("lat_first", pop_cyc[0] - first, 2);

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1), 0);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0), 0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1), 0);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, mk(32'h2222_2222, 1'b0, 1'b0), 0);
        bus.in_valid = 1'b0;
        drain();

        // Eight back-to-back beats
        pop_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            send(32'h1000_0000 * k + 32'h0F0F, 32'hF000_0001 - k, 1'(k), 1'(k >> 2),
                 model(32'h1000_0000 * k + 32'h0F0F, 32'hF000_0001 - k, 1'(k), 1'(k >> 2)), 0);
            if (k == 0) first = acc_cyc;
        end
        bus.in_valid = 1'b0;
        drain();
        chk("b2b_n", pop_cyc.size(), 8);
        if (pop_cyc.size() == 8) begin
            chk("b2b_first", pop_cyc[0] - first, 2);
            for (int k = 1; k < 8; k++) chk("b2b_gap", pop_cyc[k] - pop_cyc[k-1], 1);
        end

        // Back-pressure: downstream stalled for five cycles
        da = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        db = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444};
        idx = 0; nacc = 0; have = 0; held = '0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.c_in = 1'b0; bus.sub = 1'b0;
        bus.a = da[0]; bus.b = db[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (have) chk("hold_sum", bus.sum, held);
                else begin held = bus.sum; have = 1; end
            end
            if (bus.in_ready) begin
                sb.push_back(model(da[idx], db[idx], 1'b0, 1'b0));
                idx++; nacc++;
            end
            @(posedge clk); #1;
            if (idx < 4) begin bus.a = da[idx]; bus.b = db[idx]; end
        end
        @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 0);
        chk("stall_accepts",  nacc, 2);
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0), 0);
        send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, mk(32'h0000_0300, 1'b0, 1'b0), 0);
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_sum",   bus.sum, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        pop_cyc.delete();
        send(32'h0000_ABCD, 32'h0000_1111, 1'b1, 1'b0, mk(32'h0000_BCDF, 1'b0, 1'b0), 0);
        bus.in_valid = 1'b0;
        first = acc_cyc;
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_n", pop_cyc.size(), 1);
        if (pop_cyc.size() >= 1) chk("post_rst_lat", pop_cyc[0] - first, 2);

        // Random operands with random back-pressure and input gaps
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rc;
            logic        rs;
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1);
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal when a multiple of 2*GROUP.
REQ-002 SHALL have parameter GROUP, default 4, bits per carry-lookahead group.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  adder accepts the offered beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port c_in  input  1  carry-in; ignored when sub=1.
REQ-010 SHALL have port sub  input  1  0 = A+B+c_in, 1 = A-B.
REQ-011 SHALL have port out_valid  output  1  result beat presented.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port sum  output  WIDTH  result bits.
REQ-014 SHALL have port c_out  output  1  carry out of MSB; for sub, 1 means no borrow.
REQ-015 SHALL have port ovf  output  1  signed overflow flag.

Function
REQ-016 SHALL compute the effective operand B as b XOR {WIDTH{sub}} and the effective carry-in as sub ? 1 : c_in.
REQ-017 SHALL form per-bit g=a&b_eff, p=a^b_eff, and per-GROUP lookahead carries; no ripple path longer than one group.
REQ-018 SHALL be a two-stage pipeline: stage 1 registers the low WIDTH/2 sum, the carry into bit WIDTH/2, and the upper operand halves; stage 2 computes the upper half and registers sum, c_out, ovf.
REQ-019 SHALL have latency exactly 2 cycles from an accepted input beat to out_valid with no back-pressure.
REQ-020 SHALL accept a beat on a cycle with in_valid && in_ready; SHALL present a beat on a cycle with out_valid && out_ready.
REQ-021 SHALL drive in_ready = !v1 || !v2 || out_ready, where v1/v2 are the stage valid bits; in_ready SHALL NOT depend on in_valid.
REQ-022 SHALL advance stage 1 into stage 2 when v1 && (!v2 || out_ready); stage 2 SHALL hold sum, c_out, ovf stable while out_valid && !out_ready.
REQ-023 SHALL sustain one result per cycle when in_valid and out_ready are held high.
REQ-024 SHALL compute ovf = carry into MSB XOR c_out.
REQ-025 SHALL wrap results modulo 2^WIDTH; c_out carries the lost bit.
REQ-026 SHALL never drop or duplicate a beat under any pattern of in_valid/out_ready, including simultaneous accept and present in a full pipeline.
REQ-027 SHALL hold data registers of invalid stages at don't-care; only valid bits are reset-critical.

Reset
REQ-028 SHALL on rst_n low immediately clear v1, v2, out_valid, sum, c_out, ovf to 0, with in_ready=1 during and after reset.
REQ-029 SHALL discard any in-flight beats on reset mid-operation; no result for them SHALL appear after reset release.
REQ-030 SHALL accept a new beat on the first rising edge with rst_n high.

Structure
REQ-031 SHALL place default WIDTH and GROUP constants and a result struct type (sum, c_out, ovf) in package cla_pkg.
REQ-032 SHALL instantiate sub-module cla_group (GROUP-bit lookahead: inputs a, b, c_in; outputs sum, group G, group P) WIDTH/GROUP times via generate.
REQ-033 SHALL be synthesisable with no latches and no combinational path from out_ready to sum.

Verification
REQ-034 SHALL cover: WIDTH=32, a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0 -> 2 cycles later sum=0x00000000, c_out=1, ovf=0.
REQ-035 SHALL cover: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, c_out=0, ovf=1.
REQ-036 SHALL cover: a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, c_out=0, ovf=0; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-037 SHALL cover: 8 back-to-back beats with out_ready=1 -> 8 results on 8 consecutive cycles, first 2 cycles after first accept.
REQ-038 SHALL cover: out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts, sum held stable, order preserved on release.
REQ-039 SHALL cover: rst_n pulsed low with both stages valid -> out_valid=0 at once, no stale result after release, next beat returns correct sum.
